// File: rtl/lcd_spi_pkg.sv
`default_nettype none
//==============================================================================
// Module : lcd_spi_pkg
// Desc   : Shared types and constants for the PCD8544 SPI byte streamer.
// Rev    : 1.0 - initial release
//==============================================================================
package lcd_spi_pkg;

    // State encodings are fixed so that debug probes read stable values.
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_HIGH  = 3'd2;
    localparam logic [2:0] c_ST_LOW   = 3'd3;
    localparam logic [2:0] c_ST_END   = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_SETUP = c_ST_SETUP,
        ST_HIGH  = c_ST_HIGH,
        ST_LOW   = c_ST_LOW,
        ST_END   = c_ST_END,
        ST_GAP   = c_ST_GAP
    } state_t;

    // FIFO entry is {dc, word}; default sizing for an 8-bit LCD word.
    localparam int ENTRY_W = 8 + 1;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Entry width for an arbitrary word width.
    function automatic int entry_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_lcd_streamer_if.sv
`default_nettype none
//==============================================================================
// Module : spi_lcd_streamer_if
// Desc   : Upstream write channel carrying {dc, word} entries to the streamer.
// Rev    : 1.0 - initial release
//==============================================================================
interface spi_lcd_streamer_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_dc;
    logic [DATA_W-1:0] wr_data;

    // Upstream producer side.
    modport master (
        output wr_valid,
        output wr_dc,
        output wr_data,
        input  wr_ready
    );

    // Streamer side.
    modport slave (
        input  wr_valid,
        input  wr_dc,
        input  wr_data,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module : lcd_cmd_fifo
// Desc   : Synchronous single-clock FIFO holding {dc, word} entries.
//          Push is ignored when full, pop is ignored when empty.
// Rev    : 1.0 - initial release
//==============================================================================
module lcd_cmd_fifo
    import lcd_spi_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic [WIDTH-1:0]       i_push_data,
    input  wire logic                   i_pop,
    output logic      [WIDTH-1:0]       o_pop_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic      [$clog2(DEPTH):0] o_level
);
    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_full     = (r_level == c_FULL);
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/spi_lcd_streamer.sv
`default_nettype none
//==============================================================================
// Module : spi_lcd_streamer
// Desc   : SPI mode-0, MSB-first command/data streamer for PCD8544-class LCDs.
//          Entries are queued in a FIFO and sent with sce held low across
//          back-to-back words.
// Rev    : 1.0 - initial release
//==============================================================================
module spi_lcd_streamer
    import lcd_spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  wire logic                   clock,
    input  wire logic                   Reset,
    spi_lcd_streamer_if.slave           wr,
    output logic      [$clog2(DEPTH):0] level,
    output logic                        busy,
    output logic                        byte_done,
    output logic                        mosi,
    output logic                        sclk,
    output logic                        sce,
    output logic                        dc
);
    localparam int c_ENTRY_W = entry_width(DATA_W);
    localparam int c_BW      = $clog2(DATA_W);
    localparam int c_CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_DW      = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_DW-1:0] c_GAP_LAST = c_DW'(CS_GAP - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_W - 1);

    state_t              r_state,  w_state_nxt;
    logic [c_DW-1:0]     r_div,    w_div_nxt;
    logic [c_BW-1:0]     r_bit,    w_bit_nxt;
    logic [DATA_W-1:0]   r_shift,  w_shift_nxt;
    logic                r_mosi,   w_mosi_nxt;
    logic                r_sclk,   w_sclk_nxt;
    logic                r_sce,    w_sce_nxt;
    logic                r_dc,     w_dc_nxt;

    logic                w_pop;
    logic [c_ENTRY_W-1:0] w_pop_data;
    logic                w_full;
    logic                w_empty;
    logic [$clog2(DEPTH):0] w_level;
    logic                w_div_done;

    lcd_cmd_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst         (Reset),
        .i_push      (wr.wr_valid),
        .i_push_data ({wr.wr_dc, wr.wr_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    // The GAP phase counts chip-select idle time; all other phases count half-periods.
    assign w_div_done  = (r_div == ((r_state == ST_GAP) ? c_GAP_LAST : c_DIV_LAST));

    assign wr.wr_ready = !w_full;
    assign level       = w_level;
    assign busy        = (r_state != ST_IDLE) || !w_empty;
    assign byte_done   = (r_state == ST_END) && w_div_done;
    assign mosi        = r_mosi;
    assign sclk        = r_sclk;
    assign sce         = r_sce;
    assign dc          = r_dc;

    // Next-state, divider, shifter and pin values; pops load a fresh word.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_mosi_nxt  = r_mosi;
        w_sclk_nxt  = r_sclk;
        w_sce_nxt   = r_sce;
        w_dc_nxt    = r_dc;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_pop_data[DATA_W-1:0];
                    w_mosi_nxt  = w_pop_data[DATA_W-1];
                    w_dc_nxt    = w_pop_data[DATA_W];
                    w_bit_nxt   = '0;
                    w_sce_nxt   = 1'b0;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_div_done) begin
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_div_done) begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = 1'b0;
                    if (r_bit == c_BIT_LAST) begin
                        w_state_nxt = ST_END;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift << 1;
                        w_mosi_nxt  = r_shift[DATA_W-2];
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (w_div_done) begin
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_END: begin
                if (w_div_done) begin
                    w_div_nxt = '0;
                    if (!w_empty) begin
                        // Back-to-back word: keep sce low and restart setup.
                        w_pop       = 1'b1;
                        w_shift_nxt = w_pop_data[DATA_W-1:0];
                        w_mosi_nxt  = w_pop_data[DATA_W-1];
                        w_dc_nxt    = w_pop_data[DATA_W];
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_sce_nxt   = 1'b1;
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_div_done) begin
                    w_div_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_div_nxt   = '0;
                w_sce_nxt   = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and pin registers; reset abandons any word in flight immediately.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_mosi  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sce   <= 1'b1;
            r_dc    <= DC_CMD;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_mosi  <= w_mosi_nxt;
            r_sclk  <= w_sclk_nxt;
            r_sce   <= w_sce_nxt;
            r_dc    <= w_dc_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_lcd_streamer.sv
`default_nettype none
//==============================================================================
// Module : tb_spi_lcd_streamer
// Desc   : Self-checking bench for spi_lcd_streamer (CLK_DIV=2 and CLK_DIV=1).
// Rev    : 1.0 - initial release
//==============================================================================
module tb_spi_lcd_streamer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CD    = 2;
    localparam int CG    = 2;
    localparam int WORD_CYC = (2 * DW + 1) * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle stamp for timing checks, read only on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    spi_lcd_streamer_if #(.DATA_W(DW)) if2 ();
    spi_lcd_streamer_if #(.DATA_W(DW)) if1 ();

    logic [$clog2(DEPTH):0] level2, level1;
    logic busy2, bd2, mosi2, sclk2, sce2, dc2;
    logic busy1, bd1, mosi1, sclk1, sce1, dc1;

    spi_lcd_streamer #(.DATA_W(DW), .DEPTH(DEPTH), .CLK_DIV(CD), .CS_GAP(CG)) u_dut2 (
        .clock(clk), .Reset(rst), .wr(if2.slave), .level(level2), .busy(busy2),
        .byte_done(bd2), .mosi(mosi2), .sclk(sclk2), .sce(sce2), .dc(dc2)
    );

    spi_lcd_streamer #(.DATA_W(DW), .DEPTH(DEPTH), .CLK_DIV(1), .CS_GAP(CG)) u_dut1 (
        .clock(clk), .Reset(rst), .wr(if1.slave), .level(level1), .busy(busy1),
        .byte_done(bd1), .mosi(mosi1), .sclk(sclk1), .sce(sce1), .dc(dc1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: expected word order + line observer ----
    logic [8:0] exp_q[$];
    int         bd_cyc[$];
    bit         mon_en = 1'b1;

    logic       p_sclk = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, p_sce = 1'b1, p_bd = 1'b0;
    int         hi_run, sclk_lo, lo_run, sce_hi_run, since_fall, edges;
    bit         first_in_burst;
    logic [7:0] m_sh;
    logic       m_dc;
    logic [8:0] last_word;
    int         last_low;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            edges = 0; hi_run = 0; sclk_lo = 0; lo_run = 0;
            sce_hi_run = 100; since_fall = 0; first_in_burst = 1'b0;
        end else begin
            if (sclk2 && ({mosi2, dc2, sce2} !== {p_mosi, p_dc, p_sce}))
                chk("stable_while_sclk_high", {mosi2, dc2, sce2}, {p_mosi, p_dc, p_sce});
            if (!sce2) begin
                if (p_sce) begin
                    chk("cs_gap_min", sce_hi_run >= CG, 1);
                    lo_run = 0; since_fall = 0; first_in_burst = 1'b1;
                end
                lo_run++; since_fall++; sce_hi_run = 0;
            end else begin
                if (!p_sce) last_low = lo_run;
                sce_hi_run++;
            end
            if (!p_sclk && sclk2) begin
                chk("sce_low_at_rise", sce2, 0);
                if (first_in_burst) begin
                    chk("setup_cycles", since_fall - 1, CD);
                    first_in_burst = 1'b0;
                end
                if (edges > 0) begin
                    chk("low_phase", sclk_lo, CD);
                    chk("dc_const_in_word", dc2, m_dc);
                end else begin
                    m_dc = dc2;
                end
                m_sh = {m_sh[6:0], mosi2};
                edges++;
            end
            if (p_sclk && !sclk2) begin
                chk("high_phase", hi_run, CD);
                hi_run = 0;
            end
            if (sclk2) begin hi_run++; sclk_lo = 0; end
            else sclk_lo++;
            if (bd2) begin
                chk("bd_single_pulse", p_bd, 0);
                chk("bits_per_word", edges, DW);
                last_word = {m_dc, m_sh};
                edges = 0;
                bd_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
                else chk("word", {m_dc, m_sh}, exp_q.pop_front());
            end
        end
        p_sclk = sclk2; p_mosi = mosi2; p_dc = dc2; p_sce = sce2; p_bd = bd2;
    end

    // ---------------- drivers -------------------------------------------------
    // Leaves wr_valid high so consecutive calls push on consecutive cycles.
    task automatic push2(input logic d, input logic [7:0] b, output int acc);
        int  n = 0;
        bit  ok;
        if2.wr_valid = 1'b1; if2.wr_dc = d; if2.wr_data = b;
        @(negedge clk);
        while (!if2.wr_ready && n < 2000) begin @(negedge clk); n++; end
        ok  = if2.wr_ready;
        acc = cyc;
        @(posedge clk);
        if (ok) exp_q.push_back({d, b});
        else chk("push_ready_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_idle2(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy2 || exp_q.size() != 0) && n < budget) begin @(negedge clk); n++; end
        chk("drain_timeout", n < budget, 1);
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic [8:0] exp_word;
        int         exp_low;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int acc, r, n, rises, ones, hi, lo_in, low_sce, bds;
        logic ps;

        tbl[0] = '{1'b0, 8'h21, 9'b0_0010_0001, WORD_CYC};
        tbl[1] = '{1'b1, 8'hAA, 9'h1AA,         WORD_CYC};
        tbl[2] = '{1'b1, 8'h00, 9'h100,         WORD_CYC};
        tbl[3] = '{1'b0, 8'h80, 9'h080,         WORD_CYC};
        tbl[4] = '{1'b1, 8'h01, 9'h101,         WORD_CYC};

        if2.wr_valid = 1'b0; if2.wr_dc = 1'b0; if2.wr_data = '0;
        if1.wr_valid = 1'b0; if1.wr_dc = 1'b0; if1.wr_data = '0;

        // Reset held for five cycles.
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sce", sce2, 1);
        chk("rst_sclk", sclk2, 0);
        chk("rst_mosi", mosi2, 0);
        chk("rst_dc", dc2, 0);
        chk("rst_level", level2, 0);
        chk("rst_wr_ready", if2.wr_ready, 1);
        chk("rst_busy", busy2, 0);
        chk("rst_byte_done", bd2, 0);
        @(posedge clk); #1;

        // Table: single isolated words.
        for (int i = 0; i < 5; i++) begin
            bd_cyc.delete();
            push2(tbl[i].dc, tbl[i].data, acc);
            if2.wr_valid = 1'b0;
            wait_idle2(200);
            chk("tbl_word", last_word, tbl[i].exp_word);
            chk("tbl_sce_low", last_low, tbl[i].exp_low);
            chk("tbl_bd_count", bd_cyc.size(), 1);
            repeat (3) @(posedge clk); #1;
        end

        // Burst of three back-to-back words.
        bd_cyc.delete();
        push2(1'b0, 8'h20, acc);
        push2(1'b1, 8'hAA, acc);
        push2(1'b1, 8'h55, acc);
        if2.wr_valid = 1'b0;
        wait_idle2(400);
        chk("burst_bd_count", bd_cyc.size(), 3);
        if (bd_cyc.size() == 3) begin
            chk("burst_spacing_1", bd_cyc[1] - bd_cyc[0], WORD_CYC);
            chk("burst_spacing_2", bd_cyc[2] - bd_cyc[1], WORD_CYC);
        end
        chk("burst_sce_low", last_low, 3 * WORD_CYC);

        // Full FIFO: 17 accepted back-to-back, 18th waits for the next pop.
        repeat (3) @(posedge clk); #1;
        bd_cyc.delete();
        for (int i = 0; i < 17; i++) push2(1'(i), 8'(8'h30 + i), acc);
        chk("full_level", level2, DEPTH);
        chk("full_wr_ready", if2.wr_ready, 0);
        push2(1'b1, 8'hE7, acc);
        if2.wr_valid = 1'b0;
        chk("full_bd_before_accept", bd_cyc.size() >= 1, 1);
        if (bd_cyc.size() >= 1) chk("full_accept_after_pop", acc, bd_cyc[0] + 1);
        wait_idle2(1500);
        chk("full_bd_count", bd_cyc.size(), 18);

        // Reset in the middle of a word with two entries queued.
        repeat (3) @(posedge clk); #1;
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) push2(1'b1, 8'(8'h5A + i), acc);
        if2.wr_valid = 1'b0;
        r = 0; n = 0; ps = sclk2;
        while (r < 3 && n < 300) begin
            @(negedge clk);
            if (sclk2 && !ps) r++;
            ps = sclk2; n++;
        end
        chk("mid_rises_seen", r, 3);
        chk("mid_level", level2, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_sce", sce2, 1);
        chk("mid_rst_sclk", sclk2, 0);
        chk("mid_rst_level", level2, 0);
        chk("mid_rst_busy", busy2, 0);
        chk("mid_rst_mosi", mosi2, 0);
        rst = 1'b0;
        exp_q.delete();
        r = 0; ps = sclk2;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sclk2 && !ps) r++;
            ps = sclk2;
        end
        chk("mid_no_more_edges", r, 0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Random entries with random idle spacing, checked by the observer.
        for (int i = 0; i < 30; i++) begin
            int g;
            push2(1'($urandom_range(0, 1)), 8'($urandom()), acc);
            g = $urandom_range(0, 3);
            if (g != 0) begin
                if2.wr_valid = 1'b0;
                repeat (g * 20) @(posedge clk);
                #1;
            end
        end
        if2.wr_valid = 1'b0;
        wait_idle2(3000);

        // CLK_DIV=1 instance: one 0xFF data word.
        if1.wr_valid = 1'b1; if1.wr_dc = 1'b1; if1.wr_data = 8'hFF;
        @(posedge clk); #1 if1.wr_valid = 1'b0;
        rises = 0; ones = 0; hi = 0; lo_in = 0; low_sce = 0; bds = 0; ps = sclk1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sclk1 && !ps) begin rises++; if (mosi1) ones++; end
            if (sclk1) hi++;
            if (!sce1) begin low_sce++; if (!sclk1) lo_in++; end
            if (bd1) bds++;
            ps = sclk1;
        end
        chk("div1_rises", rises, 8);
        chk("div1_mosi_ones", ones, 8);
        chk("div1_high_cycles", hi, 8);
        chk("div1_low_cycles", lo_in, 9);
        chk("div1_word_period", low_sce, 17);
        chk("div1_bd_count", bds, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
